// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle control FSM sequencing datapath strobes for the in-house RISC core.
// Latency: FETCH..ADV is 4-6 cycles at EXEC_LAT=1 plus memory wait states; every output is registered.
// Backpressure: MEM holds rdMem/wrMem until mem_ready_i (or ERR at timeout); HALT waits for INT_i.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   opcode_i, func_i         instruction fields, sampled on the FETCH->DECODE edge
//   INT_i                    resume from HALT (ignored in every other state)
//   mem_ready_i              memory access complete, sampled only in MEM
//   aluOp_o, brOp_o          ALU operation and branch select (brOp 100 = none)
//   aluSrc_o .. isCmov_o     datapath strobes
//   halted_o, busy_o         status; mem_err_o sticky timeout flag; illegal_o one-cycle pulse
//
// Opcode map: 0 R-type, 1..15 immediate ALU, 16 LUI, 17 MOVE, 18 CMOV, 19 LD, 20 ST,
//             21 BR, 22 BMI, 23 BPL, 24 BZ, 25 NOP, 26 HALT, anything else illegal.
module multicycle_ctrl #(
  parameter int OPW         = 6,
  parameter int FUNCW       = 5,
  parameter int ALUOPW      = 4,
  parameter int EXEC_LAT    = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [OPW-1:0]    opcode_i,
  input  logic [FUNCW-1:0]  func_i,
  input  logic              INT_i,
  input  logic              mem_ready_i,
  output logic [ALUOPW-1:0] aluOp_o,
  output logic [2:0]        brOp_o,
  output logic              aluSrc_o,
  output logic              regAluOut_o,
  output logic              rdMem_o,
  output logic              wrMem_o,
  output logic              wrReg_o,
  output logic              mToReg_o,
  output logic              immSel_o,
  output logic              updPC_o,
  output logic              isCmov_o,
  output logic              halted_o,
  output logic              busy_o,
  output logic              mem_err_o,
  output logic              illegal_o
);

  localparam logic [OPW-1:0] OP_RTYPE    = OPW'(0);
  localparam logic [OPW-1:0] OP_IMM_LAST = OPW'(15);
  localparam logic [OPW-1:0] OP_LUI      = OPW'(16);
  localparam logic [OPW-1:0] OP_MOVE     = OPW'(17);
  localparam logic [OPW-1:0] OP_CMOV     = OPW'(18);
  localparam logic [OPW-1:0] OP_LD       = OPW'(19);
  localparam logic [OPW-1:0] OP_ST       = OPW'(20);
  localparam logic [OPW-1:0] OP_BR       = OPW'(21);
  localparam logic [OPW-1:0] OP_BZ       = OPW'(24);
  localparam logic [OPW-1:0] OP_NOP      = OPW'(25);
  localparam logic [OPW-1:0] OP_HALT     = OPW'(26);

  localparam logic [2:0]        BR_NONE = 3'b100;
  localparam logic [ALUOPW-1:0] ALU_ONE = ALUOPW'(1);

  // One counter serves both the EXEC settle time and the MEM wait states.
  localparam int CNT_MAX = (EXEC_LAT + 1 > MEM_TIMEOUT) ? EXEC_LAT + 1 : MEM_TIMEOUT;
  localparam int CNTW    = $clog2(CNT_MAX + 1);
  localparam logic [CNTW-1:0] CNT_ONE        = CNTW'(1);
  localparam logic [CNTW-1:0] EXEC_LAST      = CNTW'(EXEC_LAT - 1);
  localparam logic [CNTW-1:0] EXEC_LAST_CMOV = CNTW'(EXEC_LAT);
  localparam logic [CNTW-1:0] MEM_LAST       = CNTW'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ADV, S_HALT, S_ERR
  } state_e;

  // Instruction class remembered from DECODE to steer the EXEC exit.
  typedef enum logic [2:0] {
    C_ALU, C_CMOV, C_LD, C_ST, C_ADV, C_HALT
  } cls_e;

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [ALUOPW-1:0] aluOp_q, aluOp_d;
  logic [2:0]        brOp_q, brOp_d;
  logic aluSrc_q, aluSrc_d, regAluOut_q, regAluOut_d, rdMem_q, rdMem_d;
  logic wrMem_q, wrMem_d, wrReg_q, wrReg_d, mToReg_q, mToReg_d;
  logic immSel_q, immSel_d, updPC_q, updPC_d, isCmov_q, isCmov_d;
  logic halted_q, halted_d, busy_q, busy_d, mem_err_q, mem_err_d;
  logic illegal_q, illegal_d;
  logic clr_strobes;

  // Only the low ALUOPW bits of func select the ALU operation.
  logic unused_func;
  assign unused_func = ^func_i[FUNCW-1:ALUOPW];

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    cnt_d       = cnt_q;
    aluOp_d     = aluOp_q;
    brOp_d      = brOp_q;
    aluSrc_d    = aluSrc_q;
    regAluOut_d = regAluOut_q;
    rdMem_d     = rdMem_q;
    wrMem_d     = wrMem_q;
    mToReg_d    = mToReg_q;
    immSel_d    = immSel_q;
    isCmov_d    = isCmov_q;
    halted_d    = halted_q;
    busy_d      = busy_q;
    mem_err_d   = mem_err_q;
    wrReg_d     = 1'b0;
    updPC_d     = 1'b0;
    illegal_d   = 1'b0;
    clr_strobes = 1'b0;

    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (cnt_q == ((cls_q == C_CMOV) ? EXEC_LAST_CMOV : EXEC_LAST)) begin
          unique case (cls_q)
            C_ALU, C_CMOV: state_d = S_WB;
            C_LD, C_ST:    state_d = S_MEM;
            C_HALT:        state_d = S_HALT;
            default:       state_d = S_ADV;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_MEM: begin
        // Ready on the last allowed cycle still wins over the timeout.
        if (mem_ready_i) state_d = (cls_q == C_LD) ? S_WB : S_ADV;
        else if (cnt_q == MEM_LAST) state_d = S_ERR;
        else cnt_d = cnt_q + CNT_ONE;
      end
      S_WB:   state_d = S_ADV;
      S_ADV:  state_d = S_FETCH;
      S_HALT: if (INT_i) state_d = S_ADV;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are set on entry to the state they describe.
    if (state_d != state_q) begin
      unique case (state_d)
        S_FETCH: begin
          clr_strobes = 1'b1;
          brOp_d      = BR_NONE;
          busy_d      = 1'b1;
          halted_d    = 1'b0;
        end
        S_DECODE: begin
          aluOp_d     = '0;
          brOp_d      = BR_NONE;
          aluSrc_d    = 1'b0;
          regAluOut_d = 1'b0;
          immSel_d    = 1'b0;
          isCmov_d    = 1'b0;
          cls_d       = C_ADV;
          if (opcode_i == OP_RTYPE) begin
            cls_d       = C_ALU;
            aluOp_d     = func_i[ALUOPW-1:0] - ALU_ONE;
            aluSrc_d    = 1'b1;
            regAluOut_d = 1'b1;
          end else if (opcode_i <= OP_IMM_LAST) begin
            cls_d   = C_ALU;
            aluOp_d = opcode_i[ALUOPW-1:0] - ALU_ONE;
          end else if (opcode_i == OP_LUI) begin
            cls_d   = C_ALU;
            aluOp_d = '1;
          end else if (opcode_i == OP_MOVE || opcode_i == OP_CMOV) begin
            cls_d       = (opcode_i == OP_CMOV) ? C_CMOV : C_ALU;
            aluSrc_d    = 1'b1;
            regAluOut_d = 1'b1;
            isCmov_d    = (opcode_i == OP_CMOV);
          end else if (opcode_i == OP_LD) begin
            cls_d = C_LD;
          end else if (opcode_i == OP_ST) begin
            cls_d = C_ST;
          end else if (opcode_i >= OP_BR && opcode_i <= OP_BZ) begin
            brOp_d   = 3'(opcode_i - OP_BR);
            immSel_d = 1'b1;
          end else if (opcode_i == OP_HALT) begin
            cls_d = C_HALT;
          end else if (opcode_i != OP_NOP) begin
            illegal_d = 1'b1;
          end
        end
        S_EXEC: cnt_d = '0;
        S_MEM: begin
          cnt_d   = '0;
          rdMem_d = (cls_q == C_LD);
          wrMem_d = (cls_q == C_ST);
        end
        S_WB: begin
          wrReg_d  = 1'b1;
          rdMem_d  = 1'b0;
          mToReg_d = (cls_q == C_LD);
        end
        S_ADV: begin
          clr_strobes = 1'b1;
          updPC_d     = 1'b1;
          halted_d    = 1'b0;
          busy_d      = 1'b1;
        end
        S_HALT: begin
          clr_strobes = 1'b1;
          halted_d    = 1'b1;
          busy_d      = 1'b0;
        end
        S_ERR: begin
          clr_strobes = 1'b1;
          brOp_d      = BR_NONE;
          mem_err_d   = 1'b1;
          busy_d      = 1'b0;
        end
        default: ;
      endcase
    end

    if (clr_strobes) begin
      aluOp_d     = '0;
      aluSrc_d    = 1'b0;
      regAluOut_d = 1'b0;
      rdMem_d     = 1'b0;
      wrMem_d     = 1'b0;
      mToReg_d    = 1'b0;
      immSel_d    = 1'b0;
      isCmov_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cls_q       <= C_ADV;
      cnt_q       <= '0;
      aluOp_q     <= '0;
      brOp_q      <= BR_NONE;
      aluSrc_q    <= 1'b0;
      regAluOut_q <= 1'b0;
      rdMem_q     <= 1'b0;
      wrMem_q     <= 1'b0;
      wrReg_q     <= 1'b0;
      mToReg_q    <= 1'b0;
      immSel_q    <= 1'b0;
      updPC_q     <= 1'b0;
      isCmov_q    <= 1'b0;
      halted_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_err_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      cnt_q       <= cnt_d;
      aluOp_q     <= aluOp_d;
      brOp_q      <= brOp_d;
      aluSrc_q    <= aluSrc_d;
      regAluOut_q <= regAluOut_d;
      rdMem_q     <= rdMem_d;
      wrMem_q     <= wrMem_d;
      wrReg_q     <= wrReg_d;
      mToReg_q    <= mToReg_d;
      immSel_q    <= immSel_d;
      updPC_q     <= updPC_d;
      isCmov_q    <= isCmov_d;
      halted_q    <= halted_d;
      busy_q      <= busy_d;
      mem_err_q   <= mem_err_d;
      illegal_q   <= illegal_d;
    end
  end

  assign aluOp_o     = aluOp_q;
  assign brOp_o      = brOp_q;
  assign aluSrc_o    = aluSrc_q;
  assign regAluOut_o = regAluOut_q;
  assign rdMem_o     = rdMem_q;
  assign wrMem_o     = wrMem_q;
  assign wrReg_o     = wrReg_q;
  assign mToReg_o    = mToReg_q;
  assign immSel_o    = immSel_q;
  assign updPC_o     = updPC_q;
  assign isCmov_o    = isCmov_q;
  assign halted_o    = halted_q;
  assign busy_o      = busy_q;
  assign mem_err_o   = mem_err_q;
  assign illegal_o   = illegal_q;

endmodule
